// File: rtl/spi_slave.sv
// SPI mode-0 slave with synchronized pin inputs, one-word tx holding
// register and back-to-back frame support within one cs-low period.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_ni;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall;
  logic                   cs_rise, cs_fall;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             loaded_q, loaded_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             under_q, under_d;
  logic             abort_q, abort_d;
  logic             miso_q, miso_d;

  // Reset asserts immediately but releases on a clock edge.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_ni     = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    loaded_d   = loaded_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    under_d    = 1'b0;
    abort_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          tx_shift_d = loaded_q ? hold_q : '0;
          under_d    = ~loaded_q;
          loaded_d   = 1'b0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(WIDTH)) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          if (!cs_rise) begin
            tx_shift_d = loaded_q ? hold_q : '0;
            under_d    = ~loaded_q;
            loaded_d   = 1'b0;
          end
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
          cnt_d      = cnt_q + CW'(1);
        end else if (sclk_fall && cnt_q != '0) begin
          // The trailing fall after the last bit must not eat the reloaded MSB.
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = (cnt_q != '0) && (cnt_q != CW'(WIDTH));
        end
      end
      default: state_d = IDLE;
    endcase
    if (tx_valid && !loaded_q) begin
      hold_d   = tx_data;
      loaded_d = 1'b1;
    end
    miso_d = (state_d == SHIFT) ? tx_shift_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      loaded_q    <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      under_q     <= 1'b0;
      abort_q     <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      loaded_q    <= loaded_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      under_q     <= under_d;
      abort_q     <= abort_d;
      miso_q      <= miso_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~loaded_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == SHIFT);
  assign tx_underrun = under_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master plus a word-level reference
// model of the tx holding register and the expected pulse counts.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sclk = 1'b0;
  logic         cs = 1'b1;
  logic         mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         miso, tx_ready, rx_valid, busy;
  logic         tx_underrun, frame_abort;
  logic [W-1:0] rx_data;

  spi_slave #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rxv_cnt = 0;
  int un_cnt = 0;
  int ab_cnt = 0;
  int idle_bad = 0;
  int rxv_cyc = 0;
  int rise_cyc = 0;

  logic [W-1:0] held;
  bit           held_v;
  int           exp_un;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rxv_cyc <= cyc;
    end
    if (tx_underrun) un_cnt <= un_cnt + 1;
    if (frame_abort) ab_cnt <= ab_cnt + 1;
    if (!busy && miso) idle_bad <= idle_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a frame start or an in-frame reload consumes the held word,
  // or sends zeros and counts an underrun.
  function automatic logic [W-1:0] take();
    if (held_v) begin
      held_v = 1'b0;
      return held;
    end
    exp_un++;
    return '0;
  endfunction

  task automatic load(input logic [W-1:0] d);
    @(negedge clk);
    check("tx_ready_before_load", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    held     = d;
    held_v   = 1'b1;
    check("tx_ready_after_load", 32'(tx_ready), 32'd0);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic xfer(input logic [W-1:0] mo, input int nbits,
                      output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[W-1-i];
      repeat (HALF) @(negedge clk);
      mi[W-1-i] = miso;
      sclk = 1'b1;
      rise_cyc = cyc;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  logic [W-1:0] mi, mo, cur, prev_rx;
  int           b_rx, b_ab, b_un;

  initial begin
    held_v = 1'b0;
    held   = '0;
    exp_un = 0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Loaded word goes out while 0x3C comes in.
    load(8'hA5);
    b_rx = rxv_cnt;
    cs_low();
    cur = take();
    check("f1_busy", 32'(busy), 32'd1);
    check("f1_tx_ready", 32'(tx_ready), 32'd1);
    xfer(8'h3C, 8, mi);
    cur = cur;
    check("f1_latency", 32'(rxv_cyc - rise_cyc), 32'(S + 2));
    void'(take());
    cs_high();
    check("f1_miso_word", 32'(mi), 32'hA5);
    check("f1_rx_data", 32'(rx_data), 32'h3C);
    check("f1_rx_pulses", 32'(rxv_cnt - b_rx), 32'd1);
    check("f1_busy_end", 32'(busy), 32'd0);
    check("f1_underruns", 32'(un_cnt), 32'(exp_un));

    // Nothing loaded: zeros sent, underrun at frame start.
    b_un = un_cnt;
    cs_low();
    cur = take();
    check("f2_start_underrun", 32'(un_cnt - b_un), 32'd1);
    xfer(8'hFF, 8, mi);
    void'(take());
    cs_high();
    check("f2_miso_word", 32'(mi), 32'(cur));
    check("f2_rx_data", 32'(rx_data), 32'hFF);
    check("f2_underruns", 32'(un_cnt), 32'(exp_un));

    // Two frames back to back inside one cs-low period.
    b_rx = rxv_cnt;
    load(8'h12);
    cs_low();
    cur = take();
    load(8'h34);
    xfer(8'h81, 8, mi);
    check("f3a_miso_word", 32'(mi), 32'(cur));
    check("f3a_rx_data", 32'(rx_data), 32'h81);
    cur = take();
    xfer(8'h7E, 8, mi);
    check("f3b_miso_word", 32'(mi), 32'(cur));
    check("f3b_rx_data", 32'(rx_data), 32'h7E);
    check("f3b_latency", 32'(rxv_cyc - rise_cyc), 32'(S + 2));
    void'(take());
    cs_high();
    check("f3_rx_pulses", 32'(rxv_cnt - b_rx), 32'd2);
    check("f3_underruns", 32'(un_cnt), 32'(exp_un));

    // Abort after 5 bits, then a clean frame.
    b_rx = rxv_cnt;
    b_ab = ab_cnt;
    cs_low();
    cur = take();
    xfer(8'hF0, 5, mi);
    cs_high();
    check("f4_abort_pulses", 32'(ab_cnt - b_ab), 32'd1);
    check("f4_rx_pulses", 32'(rxv_cnt - b_rx), 32'd0);
    check("f4_rx_kept", 32'(rx_data), 32'h7E);
    check("f4_busy", 32'(busy), 32'd0);
    cs_low();
    cur = take();
    xfer(8'h55, 8, mi);
    void'(take());
    cs_high();
    check("f5_rx_data", 32'(rx_data), 32'h55);
    check("f5_miso_word", 32'(mi), 32'(cur));
    check("f5_rx_pulses", 32'(rxv_cnt - b_rx), 32'd1);
    check("f5_abort_pulses", 32'(ab_cnt - b_ab), 32'd1);

    // sclk activity with cs high is ignored.
    b_rx = rxv_cnt;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    check("idle_rx_pulses", 32'(rxv_cnt - b_rx), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_miso", 32'(miso), 32'd0);
    cs_low();
    cur = take();
    xfer(8'h96, 8, mi);
    void'(take());
    cs_high();
    check("idle_next_rx", 32'(rx_data), 32'h96);
    check("idle_next_pulses", 32'(rxv_cnt - b_rx), 32'd1);

    // Reset in the middle of a frame.
    b_rx = rxv_cnt;
    b_ab = ab_cnt;
    cs_low();
    cur = take();
    xfer(8'hAA, 3, mi);
    load(8'h99);
    rst = 1'b0;
    #1;
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_rx_data", 32'(rx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pulses",
          32'({rx_valid, tx_underrun, frame_abort}), 32'd0);
    held_v = 1'b0;
    cs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (HALF) @(negedge clk);
    check("post_rst_abort", 32'(ab_cnt - b_ab), 32'd0);
    check("post_rst_rx_pulses", 32'(rxv_cnt - b_rx), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    b_un = un_cnt;
    exp_un = un_cnt;
    cs_low();
    cur = take();
    xfer(8'hC3, 8, mi);
    void'(take());
    cs_high();
    check("post_rst_rx_data", 32'(rx_data), 32'hC3);
    check("post_rst_miso_word", 32'(mi), 32'(cur));
    check("post_rst_rx_pulse", 32'(rxv_cnt - b_rx), 32'd1);
    check("post_rst_underruns", 32'(un_cnt), 32'(exp_un));

    // Random frames against the model.
    for (int k = 0; k < 6; k++) begin
      prev_rx = rx_data;
      b_rx = rxv_cnt;
      if ($urandom_range(1, 0) == 1) load(8'($urandom));
      cs_low();
      cur = take();
      mo = 8'($urandom);
      xfer(mo, 8, mi);
      check("rand_latency", 32'(rxv_cyc - rise_cyc), 32'(S + 2));
      void'(take());
      cs_high();
      check("rand_miso_word", 32'(mi), 32'(cur));
      check("rand_rx_data", 32'(rx_data), 32'(mo));
      check("rand_rx_pulses", 32'(rxv_cnt - b_rx), 32'd1);
      check("rand_underruns", 32'(un_cnt), 32'(exp_un));
    end

    check("miso_idle_high", 32'(idle_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
